// File: rtl/exp_operation_ctrl_pkg.sv
// Shared types and constants for the exponent add/subtract sequencer.
// BIAS and PASS2 are only used when EXP_OPERATION_CTRL_MUL_EN is defined.
package exp_operation_ctrl_pkg;

    localparam int EXP_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PASS1 = 2'd1,
        S_PASS2 = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] CMD_DIFF     = 2'd0;
    localparam logic [1:0] CMD_MUL      = 2'd1;
    localparam logic [1:0] CMD_NORM_INC = 2'd2;
    localparam logic [1:0] CMD_NORM_DEC = 2'd3;

    function automatic int exp_bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

endpackage

// File: rtl/exp_operation_ctrl.sv
// Exponent datapath sequencer: one or two load passes, then flag resolution.
// Define EXP_OPERATION_CTRL_MUL_EN to enable MUL (second pass subtracting BIAS).
module exp_operation_ctrl
    import exp_operation_ctrl_pkg::*;
#(
    parameter int EW = EXP_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    output logic          ready_o,
    input  logic [1:0]    cmd_i,
    input  logic [EW-1:0] shift_i,
    input  logic          ovf_i,
    input  logic          unf_i,
    output logic          load_o,
    output logic          select_a_o,
    output logic          select_b_o,
    output logic          add_subt_o,
    output logic [EW-1:0] oper1_b_o,
    output logic          done_o,
    output logic          overflow_o,
    output logic          underflow_o,
    output logic          err_o
);

`ifdef EXP_OPERATION_CTRL_MUL_EN
    localparam logic [EW-1:0] BIAS = EW'(exp_bias(EW));
    logic mul_q;
    logic c1_q;
`endif

    state_e state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            ready_o     <= 1'b1;
            load_o      <= 1'b0;
            select_a_o  <= 1'b0;
            select_b_o  <= 1'b0;
            add_subt_o  <= 1'b0;
            oper1_b_o   <= '0;
            done_o      <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            err_o       <= 1'b0;
`ifdef EXP_OPERATION_CTRL_MUL_EN
            mul_q       <= 1'b0;
            c1_q        <= 1'b0;
`endif
        end else begin
            // Controls are decoded for the state being entered, so they default to idle.
            load_o     <= 1'b0;
            select_a_o <= 1'b0;
            select_b_o <= 1'b0;
            add_subt_o <= 1'b0;
            oper1_b_o  <= '0;
            done_o     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        ready_o     <= 1'b0;
                        overflow_o  <= 1'b0;
                        underflow_o <= 1'b0;
                        err_o       <= 1'b0;
`ifdef EXP_OPERATION_CTRL_MUL_EN
                        mul_q       <= (cmd_i == CMD_MUL);
                        begin
`else
                        if (cmd_i == CMD_MUL) begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                            err_o  <= 1'b1;
                        end else begin
`endif
                            state  <= S_PASS1;
                            load_o <= 1'b1;
                            case (cmd_i)
                                CMD_DIFF: add_subt_o <= 1'b1;
                                CMD_MUL:  ;
                                CMD_NORM_INC: begin
                                    select_a_o <= 1'b1;
                                    select_b_o <= 1'b1;
                                    oper1_b_o  <= EW'(1);
                                end
                                CMD_NORM_DEC: begin
                                    select_a_o <= 1'b1;
                                    select_b_o <= 1'b1;
                                    add_subt_o <= 1'b1;
                                    oper1_b_o  <= shift_i;
                                end
                            endcase
                        end
                    end
                end
                S_PASS1: begin
`ifdef EXP_OPERATION_CTRL_MUL_EN
                    if (mul_q) begin
                        // Keep the carry; it is only meaningful alongside the pass-2 borrow.
                        c1_q       <= ovf_i;
                        state      <= S_PASS2;
                        load_o     <= 1'b1;
                        select_a_o <= 1'b1;
                        select_b_o <= 1'b1;
                        add_subt_o <= 1'b1;
                        oper1_b_o  <= BIAS;
                    end else
`endif
                    begin
                        overflow_o  <= ovf_i;
                        underflow_o <= unf_i;
                        state       <= S_DONE;
                        done_o      <= 1'b1;
                    end
                end
`ifdef EXP_OPERATION_CTRL_MUL_EN
                S_PASS2: begin
                    overflow_o  <= c1_q & ~unf_i;
                    underflow_o <= ~c1_q & unf_i;
                    state       <= S_DONE;
                    done_o      <= 1'b1;
                end
`endif
                S_DONE: begin
                    state   <= S_IDLE;
                    ready_o <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/exp_operation_ctrl.md
# exp_operation_ctrl

Sequencer for the exponent add/subtract datapath of the FPU. It accepts one exponent command at a time through a start/ready handshake. It drives the datapath's load, operand-select, add/subtract and Oper1_B controls for one or two passes, then resolves the datapath carry/borrow flags into final overflow/underflow status. The datapath's Oper0_A/Oper0_B carry operand exponents EA/EB, Oper1_A is tied to the datapath's own registered result, and Oper1_B is driven by this block.

## Interface
- EW, 8, exponent width; BIAS = 2^(EW-1)-1
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- start_i  in  1  command request
- ready_o  out  1  block can accept a command (IDLE only)
- cmd_i  in  2  0=DIFF, 1=MUL, 2=NORM_INC, 3=NORM_DEC; sampled on accept
- shift_i  in  EW  normalization shift count; sampled on accept
- ovf_i  in  1  datapath Overflow flag (carry out on add)
- unf_i  in  1  datapath Underflow flag (borrow on subtract)
- load_o  out  1  datapath result-register load
- select_a_o  out  1  datapath operand-A select (0=EA, 1=result feedback)
- select_b_o  out  1  datapath operand-B select (0=EB, 1=oper1_b_o)
- add_subt_o  out  1  datapath op (0=add, 1=subtract)
- oper1_b_o  out  EW  constant operand for datapath Oper1_B
- done_o  out  1  one-cycle completion pulse
- overflow_o, underflow_o, err_o  out  1 each  status of last command, held until next accept

## Operation
- States: IDLE, PASS1, PASS2, DONE.
- IDLE: ready_o=1. On start_i=1, latch cmd_i and shift_i, clear all status, go to PASS1.
- PASS1 (load_o=1) has these per-command settings:
  - DIFF: sel A/B=0/0, subtract. Computes EA-EB.
  - MUL: sel 0/0, add. Computes EA+EB.
  - NORM_INC: sel 1/1, add, oper1_b_o=1.
  - NORM_DEC: sel 1/1, subtract, oper1_b_o=shift.
- PASS1 exit: flags are sampled on the PASS1 edge. MUL goes to PASS2; all other commands go to DONE.
- PASS2 (MUL only, load_o=1): sel 1/1, subtract, oper1_b_o=BIAS. Flags are sampled on this edge, then go to DONE.
- DONE: done_o=1, load_o=0, then go to IDLE.
- Single-pass status:
  - overflow_o = ovf_i from PASS1.
  - underflow_o = unf_i from PASS1.
  - For DIFF, underflow_o=1 means EB>EA (swap required).
- MUL status, with c1 = PASS1 carry and b2 = PASS2 borrow:
  - overflow_o = c1 & ~b2
  - underflow_o = ~c1 & b2
  - Neither flag is set when c1 and b2 are both 1 or both 0; the low EW bits are then exact.
- Outside PASS1/PASS2:
  - load_o=0.
  - select_a_o, select_b_o, add_subt_o = 0.
  - oper1_b_o = 0.
- Arithmetic is modulo 2^EW in the datapath; this block performs no arithmetic beyond the constant mux.
- start_i is ignored while ready_o=0. No queueing.

## Timing
- Accept occurs on the edge with start_i & ready_o.
- Single-pass commands: PASS1 is the cycle after accept, done_o two cycles after accept, ready_o again three cycles after accept.
- MUL: done_o three cycles after accept.
- The datapath result is valid in the done_o cycle and holds until the next load.
- Reset: rst=0 at any edge forces IDLE. Reset values: ready_o=1, every other output 0, status 0.
- Reset mid-PASS1/PASS2: load_o drops the next cycle and the command is abandoned with no done_o.
- start_i held high: exactly one accept per IDLE visit. Back-to-back commands are spaced by the DONE cycle.

## Configuration
- EXP_OPERATION_CTRL_MUL_EN defined:
  - MUL is a legal command.
  - PASS2 and the BIAS constant are compiled in.
- EXP_OPERATION_CTRL_MUL_EN undefined:
  - cmd=1 is illegal: PASS1 is skipped (load_o never asserts) and the FSM goes IDLE→DONE.
  - done_o is asserted one cycle after accept, with err_o=1.
  - PASS2 logic is absent.

## Structure
- Shared package holds:
  - the state enum;
  - command encodings CMD_DIFF/CMD_MUL/CMD_NORM_INC/CMD_NORM_DEC;
  - the BIAS function of EW.
- Single module with no sub-module; the FSM and status logic are too small to split.

## Test plan
- MUL, EW=8, EA=130, EB=129: pass1 gives 3 with c1=1; pass2 gives 132 with b2=1. Expect result=132, overflow_o=0, underflow_o=0, done_o three cycles after accept.
- MUL, EA=200, EB=200: pass1 gives 144 with c1=1; pass2 gives 17 with b2=0. Expect overflow_o=1.
- MUL, EA=10, EB=20: pass1 gives 30; pass2 borrows. Expect underflow_o=1, overflow_o=0.
- DIFF, EA=5, EB=9: expect result=252, underflow_o=1, done_o two cycles after accept; a start_i pulse during PASS1 is ignored.
- NORM_DEC with result=3, shift_i=5: expect underflow_o=1. Repeat with rst=0 asserted in PASS1: expect no done_o, ready_o=1 and load_o=0 the next cycle.
- Built without EXP_OPERATION_CTRL_MUL_EN, cmd=1: expect err_o=1, done_o one cycle after accept, load_o never asserted.
